// File: rtl/accontrol.sv
// Accumulator write control: registers the AC input-mux select and AC load
// enable from decoded instruction flags, plus a debug flag for illegal combos.
module accontrol (
  input  logic clk,
  input  logic rst_n,
  input  logic jump,
  input  logic jumpC,
  input  logic sin,
  input  logic InA,
  input  logic twone,
  output logic saidaMux,
  output logic saidaAc,
  output logic conflict
);

  logic jmpAny;
  logic muxNxt;
  logic acNxt;
  logic confNxt;

  // Any jump blocks AC writes; sin outranks twone; twone aimed at A skips AC.
  always_comb begin
    jmpAny  = jump | jumpC;
    muxNxt  = sin & ~jmpAny;
    acNxt   = ~jmpAny & (sin | (twone & ~InA));
    confNxt = (jump & jumpC) | (sin & twone) | (sin & InA);
  end

  // Reset wins over any decode so no AC load leaks through a reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      saidaMux <= 1'b0;
      saidaAc  <= 1'b0;
      conflict <= 1'b0;
    end else begin
      saidaMux <= muxNxt;
      saidaAc  <= acNxt;
      conflict <= confNxt;
    end
  end

endmodule

// File: tb/tb_accontrol.sv
// Directed bench for accontrol: each step pushes its expected outputs to a
// scoreboard queue, which is popped and compared after the registering edge.
module tb_accontrol;

  logic clk = 1'b0;
  logic rst_n;
  logic jump, jumpC, sin, InA, twone;
  logic saidaMux, saidaAc, conflict;

  typedef struct packed {
    logic mux;
    logic ac;
    logic conf;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  accontrol dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .jump     (jump),
    .jumpC    (jumpC),
    .sin      (sin),
    .InA      (InA),
    .twone    (twone),
    .saidaMux (saidaMux),
    .saidaAc  (saidaAc),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  // Reference behaviour written as the priority rules of the AC write path.
  function automatic exp_t model(input logic r, input logic j, input logic jc,
                                 input logic s, input logic a, input logic t);
    exp_t e;
    e = '0;
    if (!r) return e;
    if (j && jc) e.conf = 1'b1;
    if (s && (t || a)) e.conf = 1'b1;
    if (j || jc) begin
      e.mux = 1'b0;
      e.ac  = 1'b0;
    end else if (s) begin
      e.mux = 1'b1;
      e.ac  = 1'b1;
    end else if (t && !a) begin
      e.ac  = 1'b1;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    assert (expQ.size() > 0) else begin
      errors++;
      $error("[TB] FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      assert (saidaMux === e.mux) else begin
        errors++;
        $error("[TB] FAIL %s saidaMux observed=%b expected=%b", tag, saidaMux, e.mux);
      end
      checks++;
      assert (saidaAc === e.ac) else begin
        errors++;
        $error("[TB] FAIL %s saidaAc observed=%b expected=%b", tag, saidaAc, e.ac);
      end
      checks++;
      assert (conflict === e.conf) else begin
        errors++;
        $error("[TB] FAIL %s conflict observed=%b expected=%b", tag, conflict, e.conf);
      end
    end
  endtask

  // flags = {jump, jumpC, sin, InA, twone}
  task automatic applyStimulus(input string tag, input logic r, input logic [4:0] flags);
    @(negedge clk);
    rst_n = r;
    {jump, jumpC, sin, InA, twone} = flags;
    expQ.push_back(model(r, flags[4], flags[3], flags[2], flags[1], flags[0]));
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    {jump, jumpC, sin, InA, twone} = 5'b00000;

    $display("[TB] reset phase");
    applyStimulus("rst_all1_a", 1'b0, 5'b11111);
    applyStimulus("rst_all1_b", 1'b0, 5'b11111);
    applyStimulus("release_idle", 1'b1, 5'b00000);

    $display("[TB] jumps block writes");
    applyStimulus("jump", 1'b1, 5'b10000);
    applyStimulus("jumpC", 1'b1, 5'b01000);
    applyStimulus("both_jumps", 1'b1, 5'b11000);
    applyStimulus("jump_sin_twone", 1'b1, 5'b10101);

    $display("[TB] input load");
    applyStimulus("sin", 1'b1, 5'b00100);
    applyStimulus("sin_twone", 1'b1, 5'b00101);
    applyStimulus("sin_InA", 1'b1, 5'b00110);

    $display("[TB] ALU writeback vs register A");
    applyStimulus("twone", 1'b1, 5'b00001);
    applyStimulus("twone_InA", 1'b1, 5'b00011);
    applyStimulus("InA", 1'b1, 5'b00010);
    applyStimulus("idle", 1'b1, 5'b00000);

    $display("[TB] latency toggle");
    applyStimulus("toggle_0", 1'b1, 5'b00000);
    applyStimulus("toggle_1", 1'b1, 5'b00100);
    applyStimulus("toggle_0b", 1'b1, 5'b00000);

    $display("[TB] mid-stream reset");
    applyStimulus("pre_rst_sin", 1'b1, 5'b00100);
    applyStimulus("mid_rst_sin", 1'b0, 5'b00100);
    applyStimulus("post_rst_sin", 1'b1, 5'b00100);
    applyStimulus("post_rst_twone", 1'b1, 5'b00001);

    $display("[TB] random flag sets");
    for (int i = 0; i < 24; i++) begin
      applyStimulus("random", ($urandom_range(0, 7) != 0),
                    5'($urandom_range(0, 31)));
    end

    checks++;
    assert (expQ.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
